// File: rtl/sev_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sev_seg_pkg
// Description : Shared types and constants for the seven-segment scan
//               controller. It holds the scan FSM state type, the segment
//               "all dark" value, the active-low polarity constants and the
//               slot-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sev_seg_pkg;

  // Scan FSM: dead-time at the head of each digit slot, then drive.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // All seven segments dark (active-low lines all high).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Pin polarities. Both the digit enables and the segment lines are active-low.
  localparam logic DIG_ON = 1'b0;
  localparam logic SEG_ON = 1'b0;

  // Length of one digit slot in clock cycles.
  function automatic int slot_cycles(input int clk_hz, input int scan_hz,
                                     input int n_dig);
    return clk_hz / (scan_hz * n_dig);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sev_seg.sv
`default_nettype none
// ============================================================================
// Module      : sev_seg
// Description : Hex nibble to seven-segment decoder. The output bit order is
//               g..a, and the outputs are active-low.
// Ports       : nibble  in  4  hex digit to show
//               seg_n   out 7  segments g..a, 0 = lit
// Revision    : 1.0 - initial release
// ============================================================================
module sev_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);
  import sev_seg_pkg::*;

  logic [6:0] seg_lit;  // active-high pattern, bit 0 = segment a

  always_comb begin
    seg_lit = 7'h00;
    unique case (nibble)
      4'h0: seg_lit = 7'h3F;
      4'h1: seg_lit = 7'h06;
      4'h2: seg_lit = 7'h5B;
      4'h3: seg_lit = 7'h4F;
      4'h4: seg_lit = 7'h66;
      4'h5: seg_lit = 7'h6D;
      4'h6: seg_lit = 7'h7D;
      4'h7: seg_lit = 7'h07;
      4'h8: seg_lit = 7'h7F;
      4'h9: seg_lit = 7'h6F;
      4'hA: seg_lit = 7'h77;
      4'hB: seg_lit = 7'h7C;
      4'hC: seg_lit = 7'h39;
      4'hD: seg_lit = 7'h5E;
      4'hE: seg_lit = 7'h79;
      4'hF: seg_lit = 7'h71;
    endcase
    seg_n = SEG_ON ? seg_lit : ~seg_lit;
  end

endmodule
`default_nettype wire

// File: rtl/sev_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : sev_seg_scan
// Description : Time-multiplexed scan controller for an N_DIG-digit
//               seven-segment display. Each digit slot begins with
//               BLANK_CYC cycles of dead-time and then drives the digit.
//               A loaded value becomes visible only at a frame boundary.
//               A load that arrives mid-frame waits in a pending register,
//               and a later load replaces it.
// Ports       : CLOCK_50    in  1        system clock (rising edge)
//               KEY0        in  1        synchronous active-low reset
//               value_in    in  4*N_DIG  hex digits, nibble i -> digit i
//               load        in  1        capture strobe for value_in
//               dp_in       in  N_DIG    decimal point request, active-high
//               blank_mask  in  N_DIG    1 = force digit dark
//               seg_n       out 7        segments g..a, active-low
//               dp_n        out 1        decimal point, active-low
//               dig_n       out N_DIG    digit enables, active-low
//               frame_tick  out 1        pulse on last cycle of each frame
// Revision    : 1.0 - initial release
// ============================================================================
module sev_seg_scan #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int N_DIG     = 4,
  parameter int BLANK_CYC = 250,
  parameter int LZ_BLANK  = 0
) (
  input  logic               CLOCK_50,
  input  logic               KEY0,
  input  logic [4*N_DIG-1:0] value_in,
  input  logic               load,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   blank_mask,
  output logic [6:0]         seg_n,
  output logic               dp_n,
  output logic [N_DIG-1:0]   dig_n,
  output logic               frame_tick
);
  import sev_seg_pkg::*;

  localparam int SLOT_CYC = slot_cycles(CLK_HZ, SCAN_HZ, N_DIG);
  localparam int CNT_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int IDX_W    = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(N_DIG - 1);

  // Reject configurations that leave no drive time in a slot, or whose
  // slot length would be rounded.
  generate
    if ((SLOT_CYC <= BLANK_CYC + 1) || (BLANK_CYC < 1) ||
        ((CLK_HZ % (SCAN_HZ * N_DIG)) != 0)) begin : g_bad_cfg
      $error("sev_seg_scan: invalid CLK_HZ/SCAN_HZ/N_DIG/BLANK_CYC combination");
    end
  endgenerate

  scan_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [4*N_DIG-1:0]   shadow;
  logic [4*N_DIG-1:0]   pending;
  logic                 pend_v;

  logic                 frame_end;
  logic                 leading_zero;
  logic                 dark;
  logic                 lit;
  logic [3:0]           nibble;
  logic [6:0]           seg_dec;

  assign frame_end = (idx == IDX_LAST) && (cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      state   <= BLANK;
      cnt     <= '0;
      idx     <= '0;
      shadow  <= '0;
      pending <= '0;
      pend_v  <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        state <= BLANK;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        if (state == BLANK && cnt == CNT_BLANK_LAST) begin
          state <= DRIVE;
        end
      end

      // The shadow register changes only at a frame boundary. A load that
      // lands exactly on the boundary takes precedence over a pending value.
      if (frame_end) begin
        if (load) begin
          shadow <= value_in;
          pend_v <= 1'b0;
        end else if (pend_v) begin
          shadow <= pending;
          pend_v <= 1'b0;
        end
      end else if (load) begin
        pending <= value_in;
        pend_v  <= 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every higher digit are zero.
  // Digit 0 always shows.
  always_comb begin
    leading_zero = (idx != '0);
    for (int i = 0; i < N_DIG; i++) begin
      if (i >= 32'(idx) && shadow[4*i +: 4] != 4'h0) begin
        leading_zero = 1'b0;
      end
    end
  end

  // One shared decoder sits on the muxed nibble of the active digit.
  assign nibble = shadow[{idx, 2'b00} +: 4];

  sev_seg u_dec (
    .nibble (nibble),
    .seg_n  (seg_dec)
  );

  assign dark = blank_mask[idx] | ((LZ_BLANK != 0) & leading_zero);
  assign lit  = (state == DRIVE) & ~dark;

  always_comb begin
    dig_n = {N_DIG{~DIG_ON}};
    seg_n = SEG_OFF;
    dp_n  = 1'b1;
    if (lit) begin
      dig_n[idx] = DIG_ON;
      seg_n      = seg_dec;
      dp_n       = ~dp_in[idx];
    end
  end

  assign frame_tick = frame_end;

endmodule
`default_nettype wire

// File: tb/tb_sev_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_sev_seg_scan
// Description : Scoreboard bench for sev_seg_scan. The stimulus process
//               keeps a frame-level reference model and queues the expected
//               outputs for each cycle. A monitor checks two DUTs, one
//               without and one with leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sev_seg_scan;

  localparam int SLOT   = 20;   // 800 / (10 * 4)
  localparam int BLANKC = 4;
  localparam int FRAME  = 4 * SLOT;

  logic        clk = 1'b0;
  logic        key0 = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_mask = 4'h0;

  logic [6:0]  seg_n, seg_n_lz;
  logic        dp_n, dp_n_lz;
  logic [3:0]  dig_n, dig_n_lz;
  logic        frame_tick, frame_tick_lz;

  always #5 clk = ~clk;

  sev_seg_scan #(.CLK_HZ(800), .SCAN_HZ(10), .N_DIG(4), .BLANK_CYC(4), .LZ_BLANK(0)) dut (
    .CLOCK_50(clk), .KEY0(key0), .value_in(value_in), .load(load),
    .dp_in(dp_in), .blank_mask(blank_mask),
    .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n), .frame_tick(frame_tick));

  sev_seg_scan #(.CLK_HZ(800), .SCAN_HZ(10), .N_DIG(4), .BLANK_CYC(4), .LZ_BLANK(1)) dut_lz (
    .CLOCK_50(clk), .KEY0(key0), .value_in(value_in), .load(load),
    .dp_in(dp_in), .blank_mask(blank_mask),
    .seg_n(seg_n_lz), .dp_n(dp_n_lz), .dig_n(dig_n_lz), .frame_tick(frame_tick_lz));

  // Active-high hex patterns, bit 0 = segment a.
  logic [6:0] hex_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int         cyc;
    logic [6:0] seg, seg_lz;
    logic       dp, dp_lz;
    logic [3:0] dig, dig_lz;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed cycles since reset plus the value registers.
  bit          known = 1'b0;
  int          t = 0;
  logic [15:0] m_shadow = 16'h0, m_pending = 16'h0;
  bit          m_pend_v = 1'b0;

  function automatic void chk(input string name, input int cyc, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Apply one clock edge to the model, using the inputs held during the cycle that is ending.
  function automatic void model_edge();
    if (!key0) begin
      known     = 1'b1;
      t         = 0;
      m_shadow  = 16'h0;
      m_pending = 16'h0;
      m_pend_v  = 1'b0;
    end else if (known) begin
      if (t % FRAME == FRAME - 1) begin
        if (load) begin
          m_shadow = value_in;
          m_pend_v = 1'b0;
        end else if (m_pend_v) begin
          m_shadow = m_pending;
          m_pend_v = 1'b0;
        end
      end else if (load) begin
        m_pending = value_in;
        m_pend_v  = 1'b1;
      end
      t++;
    end
  endfunction

  function automatic void predict(input bit lz, output logic [6:0] seg, output logic dp,
                                  output logic [3:0] dig);
    int slot, phase;
    bit dark;
    slot  = (t / SLOT) % 4;
    phase = t % SLOT;
    dark  = blank_mask[slot] || (lz && slot > 0 && (m_shadow >> (4 * slot)) == 16'h0);
    seg = 7'h7F;
    dp  = 1'b1;
    dig = 4'hF;
    if (phase >= BLANKC && !dark) begin
      dig = ~(4'b0001 << slot);
      seg = ~hex_on[m_shadow[4*slot +: 4]];
      dp  = ~dp_in[slot];
    end
  endfunction

  task automatic cycle(input bit k, input bit ld, input logic [15:0] v,
                       input logic [3:0] dp, input logic [3:0] bm);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    key0 = k; load = ld; value_in = v; dp_in = dp; blank_mask = bm;
    if (known) begin
      e.cyc = t;
      predict(1'b0, e.seg, e.dp, e.dig);
      predict(1'b1, e.seg_lz, e.dp_lz, e.dig_lz);
      e.ft = (t % FRAME == FRAME - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    repeat (3) cycle(1'b0, 1'b0, 16'($urandom), 4'h0, 4'h0);
  endtask

  // Monitor: each cycle, pop one expectation and compare it away from the clock edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("dig_n",         mon_e.cyc, int'(dig_n),         int'(mon_e.dig));
      chk("seg_n",         mon_e.cyc, int'(seg_n),         int'(mon_e.seg));
      chk("dp_n",          mon_e.cyc, int'(dp_n),          int'(mon_e.dp));
      chk("frame_tick",    mon_e.cyc, int'(frame_tick),    int'(mon_e.ft));
      chk("dig_n_lz",      mon_e.cyc, int'(dig_n_lz),      int'(mon_e.dig_lz));
      chk("seg_n_lz",      mon_e.cyc, int'(seg_n_lz),      int'(mon_e.seg_lz));
      chk("dp_n_lz",       mon_e.cyc, int'(dp_n_lz),       int'(mon_e.dp_lz));
      chk("frame_tick_lz", mon_e.cyc, int'(frame_tick_lz), int'(mon_e.ft));
      chk("dig_one_low",   mon_e.cyc, int'($countones(~dig_n) <= 1), 1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] lz_masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
  bit          r_key, r_ld;
  logic [15:0] r_val;
  logic [3:0]  r_dp, r_bm;

  initial begin
    // Reset and scan order with a zero value.
    do_reset();
    for (int k = 0; k < 100; k++) cycle(1'b1, 1'b0, 16'($urandom), 4'h0, 4'h0);

    // A load mid-frame stays hidden until the next frame.
    do_reset();
    for (int k = 0; k < 200; k++)
      cycle(1'b1, k == 10, (k == 10) ? 16'h1234 : 16'($urandom), 4'h0, 4'h0);

    // When several loads arrive in one frame, the last one is used.
    do_reset();
    for (int k = 0; k < 200; k++)
      cycle(1'b1, (k == 10) || (k == 50),
            (k == 10) ? 16'hAAAA : (k == 50) ? 16'h5555 : 16'($urandom), 4'h0, 4'h0);

    // A load on the boundary cycle beats the pending value.
    do_reset();
    for (int k = 0; k < 200; k++)
      cycle(1'b1, (k == 30) || (k == 79),
            (k == 30) ? 16'h1111 : (k == 79) ? 16'hBEEF : 16'($urandom), 4'h0, 4'h0);

    // Apply the masks, with the leading-zero value 0007.
    do_reset();
    for (int k = 0; k < 200; k++)
      cycle(1'b1, k == 10, (k == 10) ? 16'h0007 : 16'($urandom), 4'h1, 4'b0100);

    // Reset during digit 2 DRIVE: first with a zero display, then with 1234 loaded.
    do_reset();
    for (int k = 0; k < 300; k++)
      cycle(!((k == 45) || (k == 171)), k == 60,
            (k == 60) ? 16'h1234 : 16'($urandom), 4'h0, 4'h0);

    // Random traffic.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      r_key = ($urandom_range(0, 399) != 0);
      r_ld  = ($urandom_range(0, 24) == 0);
      r_val = 16'($urandom) & lz_masks[$urandom_range(0, 4)];
      r_dp  = 4'($urandom);
      r_bm  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      cycle(r_key, r_ld, r_val, r_dp, r_bm);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 0, exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sev_seg_scan.md
Name: sev_seg_scan

Overview:
- Time-multiplexed scan controller for the board's 4-digit seven-segment display.
- The display's segment lines are shared between all digits. This block shares them across N_DIG digits by cycling the per-digit enables, with a blanking dead-time between digits to prevent ghosting.
- It captures a 16-bit hex value with a load strobe and applies it only at frame boundaries, so no tearing is visible.
- It sits between the counter/application logic and the HEX0/DIGx pins, and replaces the single hard-wired digit enable.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- SCAN_HZ, 1000, full-frame refresh rate (all digits once).
- N_DIG, 4, number of digits.
- BLANK_CYC, 250, dead-time cycles at the start of every digit slot.
- LZ_BLANK, 0, 1 = leading-zero suppression.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- KEY0  in  1  reset; synchronous, active-low.
- value_in  in  4*N_DIG  hex digits; nibble i is shown on digit i (digit 0 = least significant).
- load  in  1  single-cycle strobe; captures value_in.
- dp_in  in  N_DIG  decimal point request per digit, active-high.
- blank_mask  in  N_DIG  1 = force that digit dark.
- seg_n  out  7  segments g..a, active-low (0 = lit), same encoding as sev_seg.
- dp_n  out  1  decimal point, active-low.
- dig_n  out  N_DIG  digit enables, active-low (0 = on); at most one low at any time.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Slot timing: SLOT_CYC = CLK_HZ/(SCAN_HZ*N_DIG); default is 12500.
- Elaboration error if SLOT_CYC <= BLANK_CYC+1 or if CLK_HZ is not divisible by SCAN_HZ*N_DIG.
- State: FSM {BLANK, DRIVE}, cycle counter cnt (clog2(SLOT_CYC) bits), digit index idx (clog2(N_DIG) bits).
- Holding registers: shadow (4*N_DIG), pending (4*N_DIG), pend_v (1).
- Reset (KEY0=0 at a clock edge) sets:
  - state=BLANK, cnt=0, idx=0, shadow=0, pending=0, pend_v=0;
  - outputs dig_n=all 1, seg_n=7'h7F, dp_n=1, frame_tick=0.
  - Reset mid-slot or mid-frame aborts immediately; the display goes dark on the next cycle.
- Slot layout: each slot is BLANK for cnt 0..BLANK_CYC-1, then DRIVE for cnt BLANK_CYC..SLOT_CYC-1.
- Wrap: at cnt=SLOT_CYC-1, cnt goes to 0, idx goes to idx+1 (wraps N_DIG-1 to 0), and state goes to BLANK.
- BLANK outputs: dig_n all 1, seg_n=7'h7F, dp_n=1.
- DRIVE outputs:
  - dig_n[idx]=0, all other bits 1;
  - seg_n = sev_seg(shadow nibble idx);
  - dp_n = ~dp_in[idx].
- Dark digit: if blank_mask[idx]=1, or LZ_BLANK=1 and the digit is a leading zero, DRIVE behaves as BLANK for that slot.
  - Leading zero means idx>0 and all nibbles idx..N_DIG-1 of shadow are 0; digit 0 is never suppressed.
- Output timing: outputs are a combinational function of registered state and shadow, with no extra pipeline stage. dp_in and blank_mask are sampled live.
- Frame boundary: the cycle with idx=N_DIG-1 and cnt=SLOT_CYC-1. On this cycle:
  - frame_tick=1;
  - if load=1, shadow<=value_in and pend_v<=0 (the direct value wins);
  - else if pend_v, shadow<=pending and pend_v<=0.
- Load off-boundary: pending<=value_in and pend_v<=1. A later load overwrites pending (last write wins).
- shadow never changes except at a frame boundary.
- Simultaneous KEY0=0 and load: reset wins.

Decomposition:
- Package sev_seg_pkg holds:
  - the FSM state enum (BLANK, DRIVE);
  - the SEG_OFF=7'h7F constant;
  - the slot-cycle computation function;
  - the active-low polarity constants for dig and seg.
- One sub-module: the existing sev_seg nibble-to-segment decoder, instantiated once on the mux output (shared datapath, not one per digit).

Test Plan:
All scenarios use CLK_HZ=800, SCAN_HZ=10, N_DIG=4, BLANK_CYC=4, so SLOT_CYC=20. Cycle 0 is the first cycle after KEY0 rises.
- Reset/scan order: hold KEY0=0 for 3 cycles, then release with value_in=16'h0000 and no load.
  - dig_n=4'b1111 for cycles 0-3, 4'b1110 for cycles 4-19, 4'b1111 for cycles 20-23, 4'b1101 for cycles 24-39.
  - dig_n cycles 1011 -> 0111 over the following slots.
  - frame_tick=1 only at cycle 79.
- Tear-free load: load 16'h1234 at cycle 10.
  - Digits show 0 until cycle 80; from then digit0 shows 4, digit1 3, digit2 2, digit3 1.
- Last write wins: load 16'hAAAA at cycle 10 and 16'h5555 at cycle 50.
  - From cycle 80 all digits show 5; A never appears.
- Boundary load: load 16'hBEEF exactly at cycle 79 while pending holds 16'h1111.
  - From cycle 80 the display shows BEEF and pend_v=0; 1111 never appears.
- Masks: blank_mask=4'b0100 and dp_in=4'b0001.
  - dig_n[2] is never 0.
  - dp_n=0 only during digit-0 DRIVE cycles.
  - With LZ_BLANK=1 and value 16'h0007, only digit 0 is ever enabled.
- Mid-frame reset: assert KEY0=0 at cycle 45 while digit 2 is DRIVE.
  - From cycle 46: dig_n=1111, seg_n=7F, and shadow=0.
  - After release the sequence restarts at digit 0 with a BLANK phase.
